if_stage: RTL and testbench

//  Instruction fetch stage feeding the main decoder. Holds the PC, issues word reads
//  to instruction memory with a req/ack handshake, latches the returned instruction,
//  and presents op = instr[31:26] plus the full instruction to decode and execute.

---
 rtl/if_stage.sv | 85 ++++++++
 tb/tb_if_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, reads instruction memory with a req/ack
// handshake, and presents the latched instruction and opcode to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  branch_disp;
  logic [XLEN-1:0]  branch_target;

  // The address is the PC itself; keeping it a wire guarantees it is stable
  // for as long as the request is outstanding.
  assign imem_addr     = pc;
  assign pc_plus4      = pc + XLEN'(4);
  assign branch_disp   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_target = pc_plus4 + branch_disp;
  assign op            = instr[OP_MSB:OP_LSB];

  // Fetch sequencer; reset overrides everything, abandoning any open request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= START;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc          <= branch_taken ? branch_target : pc_plus4;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= START;
          instr       <= '0;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: handshake timing, sequencing, branch, stall,
// wait states, PC wrap and mid-fetch reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic        imem_ack, ack_b;
  logic [31:0] imem_rdata, rdata_b;
  logic        stall, branch_taken;
  logic [15:0] branch_offset;

  logic        imem_req, req_b;
  logic [31:0] imem_addr, addr_b, pc, pc_b, pc_plus4, pc_plus4_b, instr, instr_b;
  logic        instr_valid, valid_b;
  logic [5:0]  op, op_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid), .op(op)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .instr(instr_b), .instr_valid(valid_b), .op(op_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    imem_ack = 1'b0; ack_b = 1'b0;
    imem_rdata = '0; rdata_b = '0;
    stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    #1;
    step(); step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);

    // 1: first fetch with same-cycle ack
    rst = 1'b0;
    step();
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
    step();
    imem_ack = 1'b0;
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_op", 32'(op), 32'h23);
    check("t1_pc", pc, 32'h0);
    check("t1_pc4", pc_plus4, 32'h4);
    check("t1_req_off", 32'(imem_req), 32'd0);

    // 2: sequential fetches at 4, 8, C, 10
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t2_addr", imem_addr, 32'(4 * i));
      check("t2_valid_lo", 32'(instr_valid), 32'd0);
      check("t2_instr_nop", instr, 32'h0);
      check("t2_req", 32'(imem_req), 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h0000_1000 + 32'(i);
      step();
      imem_ack = 1'b0;
      check("t2_valid_hi", 32'(instr_valid), 32'd1);
      check("t2_instr", instr, 32'h0000_1000 + 32'(i));
    end

    // 4: stall in ISSUE with branch and stray ack asserted
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFC;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_pc", pc, 32'h10);
      check("t4_instr", instr, 32'h0000_1004);
      check("t4_valid", 32'(instr_valid), 32'd1);
      check("t4_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;

    // 3: release stall, branch back to 0x04
    stall = 1'b0;
    step();
    branch_taken = 1'b0; branch_offset = '0;
    check("t3_addr", imem_addr, 32'h04);
    check("t3_valid", 32'(instr_valid), 32'd0);

    // 5: four wait states, request held
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_req", 32'(imem_req), 32'd1);
      check("t5_addr", imem_addr, 32'h04);
      check("t5_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    check("t5_instr", instr, 32'h1234_5678);
    check("t5_op", 32'(op), 32'h04);

    // 6: wrap from 0xFFFFFFFC to 0, then reset mid-fetch
    rst_b = 1'b0;
    step();
    check("t6_addr0", addr_b, 32'hFFFF_FFFC);
    check("t6_pc4", pc_plus4_b, 32'h0);
    ack_b = 1'b1; rdata_b = 32'hAAAA_0001;
    step();
    ack_b = 1'b0;
    step();
    check("t6_wrap", addr_b, 32'h0);
    ack_b = 1'b1; rdata_b = 32'hAAAA_0002;
    step();
    ack_b = 1'b0;
    step();
    check("t6_addr2", addr_b, 32'h4);
    check("t6_req2", 32'(req_b), 32'd1);
    rst_b = 1'b1; ack_b = 1'b1; rdata_b = 32'hBBBB_0003;
    step();
    check("t6_rst_pc", pc_b, 32'hFFFF_FFFC);
    check("t6_rst_instr", instr_b, 32'h0);
    check("t6_rst_req", 32'(req_b), 32'd0);
    rst_b = 1'b0;
    step();
    ack_b = 1'b0;
    check("t6_late_valid", 32'(valid_b), 32'd0);
    check("t6_late_instr", instr_b, 32'h0);
    check("t6_refetch", addr_b, 32'hFFFF_FFFC);
    check("t6_refetch_req", 32'(req_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
